// File: rtl/cell_pkg.sv
// Shared types and colour constants for the cell display reader.
package cell_pkg;

    typedef logic [11:0] rgb_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQUEST   = 2'd1,
        WAIT_DONE = 2'd2
    } frame_state_t;

    localparam rgb_t SAND_COLOR   = 12'hFB0;
    localparam rgb_t BG_COLOR     = 12'h000;
    localparam rgb_t BORDER_COLOR = 12'hFFF;

endpackage

// File: rtl/delay_line.sv
// Fixed-depth shift register; every stage is exposed so callers can tap
// intermediate delays as well as the final output.
module delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 3
) (
    input  logic                        clk,
    input  logic                        srst,
    input  logic [WIDTH-1:0]            din,
    output logic [DEPTH-1:0][WIDTH-1:0] taps,
    output logic [WIDTH-1:0]            dout
);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [WIDTH-1:0] stage_reg;
            logic [WIDTH-1:0] stage_in;

            if (gi == 0) begin : g_head
                assign stage_in = din;
            end else begin : g_tail
                assign stage_in = g_stage[gi-1].stage_reg;
            end

            always_ff @(posedge clk) begin
                if (srst) begin
                    stage_reg <= '0;
                end else begin
                    stage_reg <= stage_in;
                end
            end

            assign taps[gi] = stage_reg;
        end
    endgenerate

    assign dout = taps[DEPTH-1];

endmodule

// File: rtl/cell_display_reader.sv
// Raster-scans the cell RAM into RGB and hands the RAM to the update engine
// once per frame during vertical blanking. Optional white frame border: BORDER_EN.
module cell_display_reader
    import cell_pkg::*;
#(
    parameter int   ACTIVE_COLUMNS = 640,
    parameter int   ACTIVE_ROWS    = 480,
    parameter int   ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS),
    parameter int   DATA_WIDTH     = 1,
    parameter int   COUNT_WIDTH    = 10,
    parameter rgb_t SAND_COLOR     = cell_pkg::SAND_COLOR,
    parameter rgb_t BG_COLOR       = cell_pkg::BG_COLOR
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [COUNT_WIDTH-1:0] hcount_i,
    input  logic [COUNT_WIDTH-1:0] vcount_i,
    input  logic                   video_on_i,
    input  logic                   hsync_i,
    input  logic                   vsync_i,
    input  logic [DATA_WIDTH-1:0]  pixel_state_i,
    input  logic                   done_i,
    output logic [ADDR_WIDTH-1:0]  rd_address_o,
    output logic                   mem_grant_o,
    output logic                   ready_o,
    output logic [11:0]            rgb_o,
    output logic                   hsync_o,
    output logic                   vsync_o,
    output logic                   frame_overrun_o
);

    localparam logic [COUNT_WIDTH-1:0] ROWS_C     = COUNT_WIDTH'(ACTIVE_ROWS);
    localparam logic [COUNT_WIDTH-1:0] LAST_ROW_C = COUNT_WIDTH'(ACTIVE_ROWS - 1);
    localparam logic [COUNT_WIDTH-1:0] LAST_COL_C = COUNT_WIDTH'(ACTIVE_COLUMNS - 1);

    logic [ADDR_WIDTH-1:0] rd_addr_reg;
    logic [ADDR_WIDTH-1:0] rd_addr_next;
    rgb_t                  rgb_reg;
    rgb_t                  rgb_next;
    frame_state_t          state_reg;
    frame_state_t          state_next;
    logic                  overrun_reg;
    logic                  overrun_next;

    logic [2:0][2:0]       sync_taps;
    logic [2:0]            sync_out;
    logic                  video_on_d2;

    logic                  vblank_start;
    logic                  frame_start;

    // ---------------- stage 1: address generation ----------------
    always_comb begin
        rd_addr_next = '0;
        if (video_on_i && (vcount_i < ROWS_C)) begin
            rd_addr_next = ADDR_WIDTH'(vcount_i) * ADDR_WIDTH'(ACTIVE_COLUMNS)
                         + ADDR_WIDTH'(hcount_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_addr_reg <= '0;
        end else begin
            rd_addr_reg <= rd_addr_next;
        end
    end

    // Bit 2 = video_on, bit 1 = hsync, bit 0 = vsync.
    delay_line #(
        .WIDTH (3),
        .DEPTH (3)
    ) u_sync_delay (
        .clk  (clk_i),
        .srst (reset_i),
        .din  ({video_on_i, hsync_i, vsync_i}),
        .taps (sync_taps),
        .dout (sync_out)
    );

    // The colour register samples video_on from two stages back so that the
    // registered colour lands together with the third sync stage.
    assign video_on_d2 = sync_taps[1][2];

`ifdef BORDER_EN
    logic border_d1_reg;
    logic border_d2_reg;
    logic border_now;

    assign border_now = video_on_i &&
                        ((hcount_i == '0) || (hcount_i == LAST_COL_C) ||
                         (vcount_i == '0) || (vcount_i == LAST_ROW_C));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            border_d1_reg <= 1'b0;
            border_d2_reg <= 1'b0;
        end else begin
            border_d1_reg <= border_now;
            border_d2_reg <= border_d1_reg;
        end
    end
`endif

    // ---------------- stage 3: colour ----------------
    always_comb begin
        rgb_next = BG_COLOR;
        if (video_on_d2 && mem_grant_o && (pixel_state_i != '0)) begin
            rgb_next = SAND_COLOR;
        end
`ifdef BORDER_EN
        if (video_on_d2 && border_d2_reg) begin
            rgb_next = BORDER_COLOR;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rgb_reg <= BG_COLOR;
        end else begin
            rgb_reg <= rgb_next;
        end
    end

    // ---------------- frame handshake ----------------
    assign vblank_start = (hcount_i == '0) && (vcount_i == ROWS_C);
    assign frame_start  = (hcount_i == '0) && (vcount_i == '0);

    always_comb begin
        state_next   = state_reg;
        overrun_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (vblank_start) begin
                    state_next = REQUEST;
                end
            end
            REQUEST: begin
                state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                // A done arriving on the wrap cycle clears the pass, so no overrun.
                if (done_i) begin
                    state_next = IDLE;
                end else if (frame_start) begin
                    overrun_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_reg   <= IDLE;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            overrun_reg <= overrun_next;
        end
    end

    assign rd_address_o    = rd_addr_reg;
    assign rgb_o           = rgb_reg;
    assign hsync_o         = sync_out[1];
    assign vsync_o         = sync_out[0];
    assign ready_o         = (state_reg == REQUEST);
    assign mem_grant_o     = (state_reg == IDLE);
    assign frame_overrun_o = overrun_reg;

endmodule

// File: tb/tb_cell_display_reader.sv
// Randomised and directed bench for cell_display_reader against a cycle-level
// reference model of the pixel path and frame handshake (BORDER_EN aware).
module tb_cell_display_reader;

    localparam int COLS = 640;
    localparam int ROWS = 480;
    localparam int AW   = 19;

    logic          clk = 1'b0;
    logic          reset;
    logic [9:0]    hcount;
    logic [9:0]    vcount;
    logic          video_on;
    logic          hsync;
    logic          vsync;
    logic [0:0]    pixel_state;
    logic          done;
    logic [AW-1:0] rd_address;
    logic          mem_grant;
    logic          ready;
    logic [11:0]   rgb;
    logic          hsync_out;
    logic          vsync_out;
    logic          frame_overrun;

    int total = 0;
    int bad   = 0;

    cell_display_reader dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .hcount_i        (hcount),
        .vcount_i        (vcount),
        .video_on_i      (video_on),
        .hsync_i         (hsync),
        .vsync_i         (vsync),
        .pixel_state_i   (pixel_state),
        .done_i          (done),
        .rd_address_o    (rd_address),
        .mem_grant_o     (mem_grant),
        .ready_o         (ready),
        .rgb_o           (rgb),
        .hsync_o         (hsync_out),
        .vsync_o         (vsync_out),
        .frame_overrun_o (frame_overrun)
    );

    always #5 clk = ~clk;

    // Cell RAM model with one-cycle registered read.
    bit mem [COLS*ROWS];
    always @(posedge clk) pixel_state <= mem[rd_address];

    // Reference model: what each past pixel request looked like, plus
    // how far along the engine handshake is (0 none, 1 just issued, 2 pending).
    typedef struct {
        bit von;
        bit brd;
        int addr;
        bit hs;
        bit vs;
    } ent_t;

    ent_t h1;
    ent_t h2;
    int   phase;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int h, input int v, input bit hs, input bit vs,
                        input bit dn, input bit rst);
        ent_t cur;
        bit   grant_before;
        int   e_rgb;
        int   e_addr;
        bit   e_hs;
        bit   e_vs;
        bit   e_ovr;
        cur.von  = (h < COLS) && (v < ROWS);
        cur.brd  = 1'b0;
`ifdef BORDER_EN
        cur.brd  = cur.von && (h == 0 || h == COLS-1 || v == 0 || v == ROWS-1);
`endif
        cur.addr = cur.von ? v * COLS + h : 0;
        cur.hs   = hs;
        cur.vs   = vs;

        hcount   = h[9:0];
        vcount   = v[9:0];
        video_on = cur.von;
        hsync    = hs;
        vsync    = vs;
        done     = dn;
        reset    = rst;
        grant_before = (phase == 0);

        @(posedge clk);
        #1;

        e_ovr = 1'b0;
        if (rst) begin
            phase  = 0;
            h1     = '{default: 0};
            h2     = '{default: 0};
            e_addr = 0;
            e_rgb  = 12'h000;
            e_hs   = 1'b0;
            e_vs   = 1'b0;
        end else begin
            if (h2.brd)
                e_rgb = 12'hFFF;
            else if (h2.von && grant_before && mem[h2.addr])
                e_rgb = 12'hFB0;
            else
                e_rgb = 12'h000;
            e_hs   = h2.hs;
            e_vs   = h2.vs;
            e_addr = cur.addr;
            case (phase)
                0: if (h == 0 && v == ROWS) phase = 1;
                1: phase = 2;
                default: begin
                    if (dn) phase = 0;
                    else if (h == 0 && v == 0) e_ovr = 1'b1;
                end
            endcase
            h2 = h1;
            h1 = cur;
        end

        $display("step h=%0d v=%0d done=%0b rst=%0b -> addr=%0d rgb=%h rdy=%0b grant=%0b ovr=%0b",
                 h, v, dn, rst, rd_address, rgb, ready, mem_grant, frame_overrun);
        chk("rd_address", 32'(rd_address), 32'(e_addr));
        chk("rgb", 32'(rgb), 32'(e_rgb));
        chk("hsync_o", 32'(hsync_out), 32'(e_hs));
        chk("vsync_o", 32'(vsync_out), 32'(e_vs));
        chk("ready", 32'(ready), 32'(phase == 1));
        chk("mem_grant", 32'(mem_grant), 32'(phase == 0));
        chk("overrun", 32'(frame_overrun), 32'(e_ovr));
    endtask

    task automatic active_burst(input int n);
        for (int i = 0; i < n; i++) begin
            step($urandom_range(0, COLS-1), $urandom_range(1, ROWS-1),
                 1'($urandom), 1'($urandom), 1'b0, 1'b0);
        end
    endtask

    task automatic blank_burst(input int n, input bit dn_last);
        for (int i = 0; i < n; i++) begin
            step($urandom_range(1, 799), $urandom_range(ROWS+1, 524),
                 1'($urandom), 1'($urandom), dn_last && (i == n-1), 1'b0);
        end
    endtask

    initial begin
        int r;
        reset = 1'b1; hcount = '0; vcount = '0; video_on = 1'b0;
        hsync = 1'b0; vsync = 1'b0; done = 1'b0;
        phase = 0;
        h1 = '{default: 0};
        h2 = '{default: 0};
        for (int i = 0; i < COLS*ROWS; i++) mem[i] = 1'($urandom);

        step(0, 0, 1'b1, 1'b1, 1'b0, 1'b1);
        step(3, 3, 1'b1, 1'b0, 1'b0, 1'b1);

        // Address and colour path at (5,2).
        mem[1285] = 1'b1;
        step(5, 2, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("plan_addr_1285", 32'(rd_address), 32'd1285);
        step(6, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        step(7, 2, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("plan_rgb_sand", 32'(rgb), 32'h0FB0);

        // Empty cell, then blanked column.
        mem[2*COLS + 10] = 1'b0;
        step(10, 2, 1'b1, 1'b1, 1'b0, 1'b0);
        step(700, 2, 1'b0, 1'b1, 1'b0, 1'b0);
        step(701, 2, 1'b1, 1'b0, 1'b0, 1'b0);
        step(702, 2, 1'b0, 1'b0, 1'b0, 1'b0);

        active_burst(300);

        // Handshake; done during the request cycle must be ignored.
        step(0, ROWS, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("plan_ready_pulse", 32'(ready), 32'd1);
        step(1, ROWS, 1'b0, 1'b1, 1'b1, 1'b0);
        blank_burst(5, 1'b1);
        chk("plan_grant_back", 32'(mem_grant), 32'd1);
        blank_burst(6, 1'b0);

        // Overrun: withhold done across the wrap and into the next vblank.
        step(0, ROWS, 1'b0, 1'b0, 1'b0, 1'b0);
        blank_burst(4, 1'b0);
        step(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("plan_overrun", 32'(frame_overrun), 32'd1);
        active_burst(60);
        step(0, ROWS, 1'b0, 1'b0, 1'b0, 1'b0);
        blank_burst(3, 1'b1);
        blank_burst(2, 1'b0);
        step(0, ROWS, 1'b0, 1'b0, 1'b0, 1'b0);
        blank_burst(2, 1'b0);

        // Done on the wrap cycle wins over overrun.
        step(0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        active_burst(20);

        // Reset while waiting for the engine.
        step(0, ROWS, 1'b0, 1'b0, 1'b0, 1'b0);
        blank_burst(3, 1'b0);
        step(4, 490, 1'b1, 1'b1, 1'b0, 1'b1);
        blank_burst(3, 1'b0);
        step(0, ROWS, 1'b0, 1'b0, 1'b0, 1'b0);
        blank_burst(3, 1'b1);

        // Border pixel with an empty cell.
        mem[100*COLS] = 1'b0;
        step(0, 100, 1'b0, 1'b0, 1'b0, 1'b0);
        active_burst(2);

        // Mixed random traffic, biased towards the frame boundaries.
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 7));
            if (r == 0)
                step(0, ROWS, 1'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0), 1'b0);
            else if (r == 1)
                step(0, 0, 1'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0), 1'b0);
            else
                step($urandom_range(0, 799), $urandom_range(0, 524), 1'($urandom), 1'($urandom),
                     ($urandom_range(0, 15) == 0), ($urandom_range(0, 199) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cell_display_reader.md
Name: cell_display_reader

Overview:
- Reader side of the cell memory. It scans the cell RAM in raster order during active video and converts each cell state to 12-bit RGB for the VGA output stage.
- Also acts as the frame-level initiator for the next-state update engine. It issues a one-cycle ready pulse at the start of vertical blanking and waits for the engine's done pulse.
- While the engine owns the RAM read port, it releases that port via mem_grant_o.

Parameters:
- ACTIVE_COLUMNS, 640, visible columns = cell-array width
- ACTIVE_ROWS, 480, visible rows = cell-array height
- ADDR_WIDTH, $clog2(ACTIVE_COLUMNS*ACTIVE_ROWS), cell RAM address width
- DATA_WIDTH, 1, cell state width
- COUNT_WIDTH, 10, width of hcount/vcount
- SAND_COLOR, 12'hFB0, RGB for any non-zero cell
- BG_COLOR, 12'h000, RGB for empty cell or blanked output

Ports:
- clk_i  in  1  pixel clock, single clock domain
- reset_i  in  1  synchronous, active-high reset
- hcount_i  in  COUNT_WIDTH  current pixel column from VGA sync
- vcount_i  in  COUNT_WIDTH  current pixel row from VGA sync
- video_on_i  in  1  high inside the active area
- hsync_i  in  1  horizontal sync from VGA sync
- vsync_i  in  1  vertical sync from VGA sync
- pixel_state_i  in  DATA_WIDTH  cell RAM read data, valid 1 cycle after rd_address_o
- done_i  in  1  one-cycle pulse from the update engine when the pass is complete
- rd_address_o  out  ADDR_WIDTH  cell RAM read address (display side)
- mem_grant_o  out  1  1 = display owns the read port; 0 = update engine owns it
- ready_o  out  1  one-cycle start pulse to the update engine
- rgb_o  out  12  pixel colour
- hsync_o  out  1  hsync_i delayed to align with rgb_o
- vsync_o  out  1  vsync_i delayed to align with rgb_o
- frame_overrun_o  out  1  one-cycle pulse, engine still busy at start of active video

Behaviour:
- Reset (synchronous): all pipeline registers clear.
  - rd_address_o=0, rgb_o=BG_COLOR, hsync_o=vsync_o=0.
  - ready_o=0, frame_overrun_o=0, mem_grant_o=1, FSM=IDLE.
- Pixel pipeline, fixed latency 3 cycles from hcount/vcount to rgb_o:
  - S1 registers rd_address_o = vcount_i*ACTIVE_COLUMNS + hcount_i, computed at ADDR_WIDTH, when video_on_i=1 and vcount_i<ACTIVE_ROWS; otherwise holds 0.
  - S2: RAM returns pixel_state_i.
  - S3 registers rgb_o = SAND_COLOR if the delayed video_on=1, mem_grant_o=1 and pixel_state_i!=0. Otherwise rgb_o=BG_COLOR.
  - video_on, hsync and vsync travel through a 3-deep shift register alongside the data.
- Frame FSM states: IDLE, REQUEST, WAIT_DONE.
  - IDLE: on hcount_i==0 && vcount_i==ACTIVE_ROWS (first blanking line) -> REQUEST.
  - REQUEST: ready_o=1 for exactly one cycle; mem_grant_o=0; -> WAIT_DONE.
  - WAIT_DONE: mem_grant_o=0.
    - done_i=1 -> IDLE, with mem_grant_o=1 from the next cycle.
    - hcount_i==0 && vcount_i==0 (active video resumes) while waiting: pulse frame_overrun_o for 1 cycle and stay in WAIT_DONE. Output is BG_COLOR until done.
- done_i outside WAIT_DONE is ignored. No new request is issued while in WAIT_DONE, so there is at most one request outstanding.
- done_i in the same cycle as the vcount_i==0 overrun check: done wins, no overrun pulse.
- Reset mid-frame or mid-request: FSM returns to IDLE, ready_o is dropped, and the next vblank issues a fresh request.

Optional Feature:
- Macro BORDER_EN.
  - Defined: pixels with hcount==0, hcount==ACTIVE_COLUMNS-1, vcount==0 or vcount==ACTIVE_ROWS-1 output 12'hFFF when video_on, regardless of cell state or mem_grant_o. The border flag is pipelined with the data.
  - Undefined: no border logic; rgb_o comes from cell state only.

Decomposition:
- Package cell_pkg holds:
  - the frame FSM typedef enum (IDLE, REQUEST, WAIT_DONE);
  - colour constants SAND_COLOR and BG_COLOR;
  - the 12-bit RGB typedef.
- One sub-module, delay_line (parameterised WIDTH and DEPTH = 3), aligns video_on, hsync and vsync.

Test Plan:
- Address and colour path:
  - Stimulus: hcount=5, vcount=2; RAM model returns 1 at address 1285.
  - Required: rd_address_o=1285 one cycle later, rgb_o=12'hFB0 three cycles after the input.
- Empty cell and blanking:
  - Stimulus: cell=0 with video_on=1, then any cell with video_on=0.
  - Required: rgb_o=12'h000 in both cases; hsync_o/vsync_o equal inputs delayed by exactly 3 cycles.
- Handshake:
  - Stimulus: vcount reaches 480 at hcount 0.
  - Required: ready_o high for exactly 1 cycle and mem_grant_o=0. After done_i pulses, mem_grant_o=1 on the next cycle and no further ready_o until the next vcount=480.
- Overrun:
  - Stimulus: withhold done_i past the vcount=0 wrap.
  - Required: frame_overrun_o pulses once, rgb_o=12'h000 for all active pixels, and no ready_o at the next vblank until done_i arrives.
- Reset mid-WAIT_DONE:
  - Stimulus: assert reset_i for 1 cycle.
  - Required: mem_grant_o=1, ready_o=0, rgb_o=12'h000, and the next vblank issues a fresh ready_o.
- BORDER_EN build:
  - Stimulus: pixel (0,100) with cell=0.
  - Required: rgb_o=12'hFFF three cycles later.
